// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
// Shared constants and types for the core front-end scheduler.
//   LINE_W   : cache line width fed to the core
//   ADDR_W   : result slot index width
//   N_SLOTS  : number of result slots in the core
//   RES_W    : width of a core result word
//   ID_W     : requester id width carried in a response (four requesters)
//   resp_t   : response record {id, slot, resultado} held in the response FIFO
//   first_free() : lowest-index free slot of a busy vector
// -----------------------------------------------------------------------------
package core_pkg;

    localparam int LINE_W  = 512;
    localparam int ADDR_W  = 2;
    localparam int N_SLOTS = 2 ** ADDR_W;
    localparam int RES_W   = 32;
    localparam int ID_W    = 2;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] slot;
        logic [RES_W-1:0]  resultado;
    } resp_t;

    // Scanning downwards makes the last assignment the lowest free index.
    // Returns 0 when every slot is busy; callers qualify with a free flag.
    function automatic logic [ADDR_W-1:0] first_free(input logic [N_SLOTS-1:0] busy);
        first_free = '0;
        for (int s = N_SLOTS - 1; s >= 0; s--) begin
            if (!busy[s]) begin
                first_free = ADDR_W'(s);
            end
        end
    endfunction

endpackage

// File: rtl/core_scheduler_if.sv
// -----------------------------------------------------------------------------
// core_scheduler_if
// Bundles the three channels of the scheduler:
//   requester side : req_valid, req_linha (N_REQ lines packed), req_ready
//   core side      : core_linha, core_endereco, core_valid, core_resultado
//   response side  : resp_valid, resp_ready, resp_id, resp_endereco,
//                    resp_resultado
// master : the scheduler's view (drives grants, core inputs, responses)
// slave  : the environment's view (requesters, core, response consumer)
// -----------------------------------------------------------------------------
interface core_scheduler_if #(
    parameter int N_REQ  = 4,
    parameter int LINE_W = core_pkg::LINE_W,
    parameter int ADDR_W = core_pkg::ADDR_W,
    parameter int RES_W  = core_pkg::RES_W
);
    localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*LINE_W-1:0] req_linha;
    logic [N_REQ-1:0]        req_ready;

    logic [LINE_W-1:0]       core_linha;
    logic [ADDR_W-1:0]       core_endereco;
    logic                    core_valid;
    logic [RES_W-1:0]        core_resultado;

    logic                    resp_valid;
    logic                    resp_ready;
    logic [IDW-1:0]          resp_id;
    logic [ADDR_W-1:0]       resp_endereco;
    logic [RES_W-1:0]        resp_resultado;

    modport master (
        input  req_valid, req_linha, core_resultado, resp_ready,
        output req_ready, core_linha, core_endereco, core_valid,
               resp_valid, resp_id, resp_endereco, resp_resultado
    );

    modport slave (
        output req_valid, req_linha, core_resultado, resp_ready,
        input  req_ready, core_linha, core_endereco, core_valid,
               resp_valid, resp_id, resp_endereco, resp_resultado
    );

endinterface

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter with an internal priority pointer.
//   clk, reset : clock and synchronous active-high reset
//   req        : per-requester request bits
//   enable     : when low no grant is issued and the pointer holds
//   grant      : one-hot grant, first requester at or after the pointer
// After a grant the pointer moves to the requester following the winner.
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic             enable,
    output logic [N_REQ-1:0] grant
);
    import core_pkg::*;

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] next_ptr;
    logic [PTR_W-1:0] scan_idx;
    logic             found;

    // Rotating search starting at ptr; only the first hit is granted.
    always_comb begin
        grant    = '0;
        next_ptr = ptr;
        scan_idx = '0;
        found    = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            scan_idx = PTR_W'((int'(ptr) + i) % N_REQ);
            if (enable && !found && req[scan_idx]) begin
                found           = 1'b1;
                grant[scan_idx] = 1'b1;
                next_ptr        = PTR_W'((int'(scan_idx) + 1) % N_REQ);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= next_ptr;
        end
    end

endmodule

// File: rtl/core_scheduler.sv
// -----------------------------------------------------------------------------
// core_scheduler
// Front end for the signature-matching core. Accepts cache lines from N_REQ
// requesters in round-robin order, gives each accepted line a free result
// slot, drives it into the core, captures the result CORE_LAT cycles later
// and returns {id, slot, result} through a 4-entry ready/valid FIFO. A slot
// stays busy until its response leaves the FIFO.
//   clk, reset : clock and synchronous active-high reset
//   bus        : core_scheduler_if.master
//                 requester channel  req_valid / req_linha / req_ready
//                 core channel       core_linha / core_endereco / core_valid
//                                    core_resultado
//                 response channel   resp_valid / resp_ready / resp_id /
//                                    resp_endereco / resp_resultado
// -----------------------------------------------------------------------------
module core_scheduler #(
    parameter int N_REQ    = 4,
    parameter int LINE_W   = core_pkg::LINE_W,
    parameter int ADDR_W   = core_pkg::ADDR_W,
    parameter int RES_W    = core_pkg::RES_W,
    parameter int CORE_LAT = 1
) (
    input logic               clk,
    input logic               reset,
    core_scheduler_if.master  bus
);
    import core_pkg::*;

    localparam int SLOTS = 2 ** ADDR_W;

    // Slot table and arbitration
    logic [SLOTS-1:0]  busy;
    logic              any_free;
    logic [ADDR_W-1:0] alloc_slot;
    logic [N_REQ-1:0]  grant;
    logic              handshake;
    logic [ID_W-1:0]   hs_id;
    logic [LINE_W-1:0] hs_line;

    // Issue register
    logic              core_valid_q;
    logic [LINE_W-1:0] core_linha_q;
    logic [ADDR_W-1:0] core_endereco_q;
    logic [ID_W-1:0]   issue_id;

    // Latency pipe
    logic [CORE_LAT-1:0] pipe_valid;
    logic [ID_W-1:0]     pipe_id   [CORE_LAT];
    logic [ADDR_W-1:0]   pipe_slot [CORE_LAT];

    // Response FIFO
    resp_t             fifo_mem [SLOTS];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    resp_t             head;
    resp_t             hold_q;
    resp_t             push_data;
    resp_t             resp_out;
    logic              push;
    logic              pop;
    logic              resp_valid;

    assign any_free   = ~&busy;
    assign alloc_slot = first_free(busy);

    // Reset gates the enable so no grant is shown during the reset cycle,
    // whatever the slot table held before it.
    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .clk    (clk),
        .reset  (reset),
        .req    (bus.req_valid),
        .enable (any_free & ~reset),
        .grant  (grant)
    );

    assign bus.req_ready = grant;
    assign handshake     = |grant;

    // The arbiter only grants requesters that are valid, so a grant bit is a
    // handshake; this just encodes the winner and selects its line.
    always_comb begin
        hs_id   = '0;
        hs_line = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                hs_id   = ID_W'(i);
                hs_line = bus.req_linha[i*LINE_W +: LINE_W];
            end
        end
    end

    // Issue register: data outputs hold between handshakes.
    always_ff @(posedge clk) begin
        if (reset) begin
            core_valid_q    <= 1'b0;
            core_linha_q    <= '0;
            core_endereco_q <= '0;
            issue_id        <= '0;
        end else begin
            core_valid_q <= handshake;
            if (handshake) begin
                core_linha_q    <= hs_line;
                core_endereco_q <= alloc_slot;
                issue_id        <= hs_id;
            end
        end
    end

    assign bus.core_valid    = core_valid_q;
    assign bus.core_linha    = core_linha_q;
    assign bus.core_endereco = core_endereco_q;

    // Latency pipe valids; reset discards anything still inside the core.
    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_valid <= '0;
        end else begin
            pipe_valid[0] <= core_valid_q;
            for (int k = 1; k < CORE_LAT; k++) begin
                pipe_valid[k] <= pipe_valid[k-1];
            end
        end
    end

    // Latency pipe payload travels alongside the valids and needs no reset.
    always_ff @(posedge clk) begin
        pipe_id[0]   <= issue_id;
        pipe_slot[0] <= core_endereco_q;
        for (int k = 1; k < CORE_LAT; k++) begin
            pipe_id[k]   <= pipe_id[k-1];
            pipe_slot[k] <= pipe_slot[k-1];
        end
    end

    assign push = pipe_valid[CORE_LAT-1];

    always_comb begin
        push_data           = '0;
        push_data.id        = pipe_id[CORE_LAT-1];
        push_data.slot      = pipe_slot[CORE_LAT-1];
        push_data.resultado = bus.core_resultado;
    end

    assign head       = fifo_mem[rd_ptr];
    assign resp_valid = (count != '0);
    assign pop        = resp_valid & bus.resp_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= push_data;
        end
    end

    // FIFO pointers and occupancy. At most SLOTS responses can be outstanding,
    // so a push never finds the FIFO full. hold_q keeps the last popped entry
    // so the response outputs stay put while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            hold_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                hold_q <= head;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Slot table. The popped slot and the allocated slot can never be the
    // same entry, and a freed slot only becomes allocatable next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= '0;
        end else begin
            if (handshake) begin
                busy[alloc_slot] <= 1'b1;
            end
            if (pop) begin
                busy[head.slot] <= 1'b0;
            end
        end
    end

    assign resp_out           = resp_valid ? head : hold_q;
    assign bus.resp_valid     = resp_valid;
    assign bus.resp_id        = resp_out.id;
    assign bus.resp_endereco  = resp_out.slot;
    assign bus.resp_resultado = resp_out.resultado;

endmodule

// File: tb/tb_core_scheduler.sv
// -----------------------------------------------------------------------------
// tb_core_scheduler
// Drives core_scheduler with directed and random requester traffic, models the
// core as a fixed-latency function of the issued line and slot, and predicts
// grants, slot use and responses from a behavioural model of the scheduler's
// rules. A separate monitor process pops the expected-response queue whenever
// a response is handed over and compares it.
// -----------------------------------------------------------------------------
module tb_core_scheduler;
    import core_pkg::*;

    localparam int N_REQ    = 4;
    localparam int CORE_LAT = 1;
    localparam logic [31:0] SIG = 32'hC0DE_5EED;

    typedef struct {
        int                id;
        int                slot;
        logic [RES_W-1:0]  res;
        int                due;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    core_scheduler_if #(.N_REQ(N_REQ)) bus ();

    core_scheduler #(.N_REQ(N_REQ), .CORE_LAT(CORE_LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit armed  = 1'b0;

    // Scheduler model state
    exp_t              sb[$];
    bit                model_busy [N_SLOTS];
    int                model_ptr;
    bit [N_REQ-1:0]    pend;
    logic [LINE_W-1:0] pline [N_REQ];
    bit                exp_cv;
    logic [ADDR_W-1:0] exp_slot;
    logic [LINE_W-1:0] exp_line;

    // Last response handed over, used to check the hold behaviour when empty
    int               last_id;
    int               last_slot;
    logic [RES_W-1:0] last_res;

    // Behavioural core: XOR-fold of the line's words; a match is a fold equal
    // to the signature. The result also carries the slot so slot errors show.
    function automatic logic [RES_W-1:0] core_fn(input logic [LINE_W-1:0] line,
                                                 input logic [ADDR_W-1:0] slot);
        logic [31:0] f;
        f = '0;
        for (int w = 0; w < LINE_W / 32; w++) begin
            f ^= line[w*32 +: 32];
        end
        return {f[31:3], slot, (f == SIG)};
    endfunction

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] l;
        for (int w = 0; w < LINE_W / 32; w++) begin
            l[w*32 +: 32] = $urandom;
        end
        return l;
    endfunction

    // Core stand-in: result appears CORE_LAT cycles after the line was shown.
    logic [RES_W-1:0] cpipe [CORE_LAT];

    always @(posedge clk) begin
        cpipe[0] <= core_fn(bus.core_linha, bus.core_endereco);
        for (int k = 1; k < CORE_LAT; k++) begin
            cpipe[k] <= cpipe[k-1];
        end
    end

    assign bus.core_resultado = cpipe[CORE_LAT-1];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [LINE_W-1:0] act,
                               input logic [LINE_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle of stimulus plus the request-side and core-side checks.
    task automatic applyStimulus(input bit rst, input bit rdy, input int new_prob,
                                 input logic [N_REQ-1:0] force_mask);
        int               g;
        int               slot;
        int               idx;
        logic [N_REQ-1:0] exp_ready;
        @(negedge clk);
        reset          = rst;
        bus.resp_ready = rdy;
        if (rst) begin
            sb.delete();
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!pend[i] && (force_mask[i] || (int'($urandom_range(99)) < new_prob))) begin
                pend[i]  = 1'b1;
                pline[i] = rand_line();
            end
            bus.req_valid[i]                  = pend[i];
            bus.req_linha[i*LINE_W +: LINE_W] = pline[i];
        end
        #1;
        g    = -1;
        slot = -1;
        for (int s = 0; s < N_SLOTS; s++) begin
            if (!model_busy[s] && slot < 0) slot = s;
        end
        if (!rst && slot >= 0) begin
            for (int k = 0; k < N_REQ; k++) begin
                idx = (model_ptr + k) % N_REQ;
                if (g < 0 && pend[idx]) g = idx;
            end
        end
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        if (armed) begin
            checkOutput("req_ready", bus.req_ready, exp_ready);
            checkOutput("core_valid", bus.core_valid, exp_cv);
            checkOutput("core_endereco", bus.core_endereco, exp_slot);
            checkOutput("core_linha", bus.core_linha, exp_line);
        end
        if (rst) begin
            for (int s = 0; s < N_SLOTS; s++) model_busy[s] = 1'b0;
            model_ptr = 0;
            exp_cv    = 1'b0;
            exp_slot  = '0;
            exp_line  = '0;
        end else if (g >= 0) begin
            model_busy[slot] = 1'b1;
            model_ptr        = (g + 1) % N_REQ;
            sb.push_back('{id: g, slot: slot,
                           res: core_fn(pline[g], ADDR_W'(slot)),
                           due: cyc + 2 + CORE_LAT});
            exp_cv   = 1'b1;
            exp_slot = ADDR_W'(slot);
            exp_line = pline[g];
            pend[g]  = 1'b0;
        end else begin
            exp_cv = 1'b0;
        end
    endtask

    task automatic drainAll();
        for (int n = 0; n < 60; n++) begin
            if (sb.size() == 0 && pend == '0) break;
            applyStimulus(1'b0, 1'b1, 0, '0);
        end
        checkOutput("drain_empty", sb.size(), 0);
    endtask

    // Monitor: compares each response the DUT presents against the head of
    // the expected queue, including that it arrives neither early nor late.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (reset !== 1'b0) continue;
            if (bus.resp_valid) begin
                if (sb.size() == 0) begin
                    checkOutput("resp_unexpected", bus.resp_valid, 1'b0);
                end else begin
                    checkOutput("resp_not_early", (cyc >= sb[0].due), 1'b1);
                    checkOutput("resp_id", bus.resp_id, sb[0].id);
                    checkOutput("resp_endereco", bus.resp_endereco, sb[0].slot);
                    checkOutput("resp_resultado", bus.resp_resultado, sb[0].res);
                    if (bus.resp_ready) begin
                        last_id   = sb[0].id;
                        last_slot = sb[0].slot;
                        last_res  = sb[0].res;
                        model_busy[sb[0].slot] = 1'b0;
                        void'(sb.pop_front());
                    end
                end
            end else if (sb.size() > 0 && sb[0].due <= cyc) begin
                checkOutput("resp_valid_late", bus.resp_valid, 1'b1);
            end
        end
    end

    initial begin
        logic [LINE_W-1:0] g0;
        logic [LINE_W-1:0] g1;
        logic [LINE_W-1:0] g2;

        reset          = 1'b1;
        bus.resp_ready = 1'b0;
        bus.req_valid  = '0;
        bus.req_linha  = '0;
        pend           = '0;
        model_ptr      = 0;
        exp_cv         = 1'b0;
        exp_slot       = '0;
        exp_line       = '0;
        for (int s = 0; s < N_SLOTS; s++) model_busy[s] = 1'b0;
        for (int i = 0; i < N_REQ; i++) pline[i] = '0;

        // Reset and reset values
        applyStimulus(1'b1, 1'b0, 0, '0);
        armed = 1'b1;
        applyStimulus(1'b1, 1'b0, 0, '0);
        applyStimulus(1'b0, 1'b0, 0, '0);
        checkOutput("reset_resp_valid", bus.resp_valid, 1'b0);
        checkOutput("reset_resp_id", bus.resp_id, 0);
        checkOutput("reset_resp_endereco", bus.resp_endereco, 0);
        checkOutput("reset_resp_resultado", bus.resp_resultado, 0);

        // Single request from requester 2
        $display("[TB] single request");
        applyStimulus(1'b0, 1'b1, 0, 4'b0100);
        for (int n = 0; n < 6; n++) applyStimulus(1'b0, 1'b1, 0, '0);

        // All requesters busy, consumer always ready
        $display("[TB] streaming round-robin");
        for (int n = 0; n < 16; n++) applyStimulus(1'b0, 1'b1, 0, 4'b1111);
        drainAll();

        // Backpressure: only four accepted, then the rest follow pops
        $display("[TB] backpressure");
        for (int n = 0; n < 8; n++) applyStimulus(1'b0, 1'b0, 0, 4'b1111);
        drainAll();

        // Randomised traffic with random backpressure
        $display("[TB] random traffic");
        for (int n = 0; n < 400; n++) begin
            applyStimulus(1'b0, ($urandom_range(3) != 0), 40, '0);
        end
        drainAll();

        // Reset with three slots busy and responses queued
        $display("[TB] reset with work in flight");
        applyStimulus(1'b0, 1'b0, 0, 4'b0111);
        for (int n = 0; n < 4; n++) applyStimulus(1'b0, 1'b0, 0, '0);
        applyStimulus(1'b1, 1'b0, 0, '0);
        applyStimulus(1'b0, 1'b1, 0, '0);
        checkOutput("post_reset_resp_valid", bus.resp_valid, 1'b0);
        for (int n = 0; n < 8; n++) applyStimulus(1'b0, 1'b1, 0, '0);

        // Golden lines: one signature, one XOR-colliding, one disguised signature
        $display("[TB] golden lines");
        g0 = '0;
        g0[0*32 +: 32]  = SIG;
        g1 = '0;
        g1[0*32 +: 32]  = SIG;
        g1[5*32 +: 32]  = SIG;
        g2 = '0;
        g2[2*32 +: 32]  = SIG;
        g2[7*32 +: 32]  = 32'h1234_5678;
        g2[11*32 +: 32] = 32'h1234_5678;
        pend     = 4'b0111;
        pline[0] = g0;
        pline[1] = g1;
        pline[2] = g2;
        for (int n = 0; n < 8; n++) applyStimulus(1'b0, 1'b1, 0, '0);
        checkOutput("golden_last_match", last_res[0], 1'b1);
        drainAll();

        // Empty FIFO keeps the last response on the outputs
        applyStimulus(1'b0, 1'b1, 0, '0);
        checkOutput("empty_resp_valid", bus.resp_valid, 1'b0);
        checkOutput("hold_resp_id", bus.resp_id, last_id);
        checkOutput("hold_resp_endereco", bus.resp_endereco, last_slot);
        checkOutput("hold_resp_resultado", bus.resp_resultado, last_res);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
